// File: rtl/ctrl_pkg.sv
// Shared definitions for the fetch/decode/dispatch sequencer and its helpers.
package ctrl_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_RETIRE = 3'd4,
      ST_HALT   = 3'd5,
      ST_FAULT  = 3'd6
   } state_e;

   // Opcodes with special meaning to the sequencer
   localparam logic [3:0] OP_MOV  = 4'h0;
   localparam logic [3:0] OP_MOVI = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Fault codes reported on fault_code
   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_ILLEGAL  = 2'b01;
   localparam logic [1:0] FC_WATCHDOG = 2'b10;
   localparam logic [1:0] FC_SPURIOUS = 2'b11;

   // One-hot select line for an execute FSM
   function automatic logic [15:0] onehot16(input logic [3:0] op);
      onehot16 = 16'h0001 << op;
   endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Cycle counter for the EXEC state; flags when the execute FSM has used its
// last allowed cycle without signalling done.
module exec_watchdog
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] count_q, count_d;

   // Next count: clear has priority over counting
   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = 8'd0;
      else if (en)
         count_d = count_q + 8'd1;
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= 8'd0;
      else
         count_q <= count_d;
   end

   assign expired = en && (count_q == LIMIT);

endmodule

// File: rtl/instr_dispatch_ctrl.sv
// Fetch/decode/dispatch sequencer: latches one instruction, starts its
// execute FSM, waits for done, counts retirements, traps HALT and faults.
module instr_dispatch_ctrl
   import ctrl_pkg::*;
#(
   parameter logic [15:0] OP_EN   = 16'h003F,
   parameter int          TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        clear_fault,
   input  logic [15:0] instr_in,
   input  logic        instr_valid,
   input  logic [15:0] op_done,
   output logic        fetch_req,
   output logic [15:0] ir,
   output logic [15:0] op_start,
   output logic        busy,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [15:0] retire_cnt
);

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] op_start_q, op_start_d;
   logic [15:0] retire_cnt_q, retire_cnt_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic        fetch_req_q, busy_q, halted_q, fault_q;

   logic        wd_clr, wd_en, wd_expired;
   logic [3:0]  opcode;
   logic [15:0] op_mask;
   logic        match_done, spurious_done;

   assign opcode        = ir_q[15:12];
   assign op_mask       = onehot16(opcode);
   assign match_done    = |(op_done & op_mask);
   assign spurious_done = |(op_done & ~op_mask);

   exec_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Next-state and next-output decisions for the sequencer
   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      op_start_d   = 16'h0000;
      fault_code_d = fault_code_q;
      retire_cnt_d = retire_cnt_q;
      wd_clr       = 1'b0;
      wd_en        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run)
               state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (instr_valid) begin
               ir_d    = instr_in;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            wd_clr = 1'b1;
            if (opcode == OP_HALT) begin
               state_d = ST_HALT;
            end else if (!OP_EN[opcode]) begin
               state_d      = ST_FAULT;
               fault_code_d = FC_ILLEGAL;
            end else begin
               op_start_d = op_mask;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            wd_en = 1'b1;
            // A stray done is worse than a late one, so it is checked first;
            // a matching done on the final allowed cycle still retires.
            if (spurious_done) begin
               state_d      = ST_FAULT;
               fault_code_d = FC_SPURIOUS;
            end else if (match_done) begin
               state_d = ST_RETIRE;
            end else if (wd_expired) begin
               state_d      = ST_FAULT;
               fault_code_d = FC_WATCHDOG;
            end
         end
         ST_RETIRE: begin
            retire_cnt_d = retire_cnt_q + 16'd1;
            state_d      = run ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         ST_FAULT: begin
            if (clear_fault) begin
               state_d      = ST_IDLE;
               fault_code_d = FC_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; status flags are decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ir_q         <= 16'h0000;
         op_start_q   <= 16'h0000;
         retire_cnt_q <= 16'h0000;
         fault_code_q <= FC_NONE;
         fetch_req_q  <= 1'b0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         op_start_q   <= op_start_d;
         retire_cnt_q <= retire_cnt_d;
         fault_code_q <= fault_code_d;
         fetch_req_q  <= (state_d == ST_FETCH);
         busy_q       <= (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                         (state_d == ST_EXEC)  || (state_d == ST_RETIRE);
         halted_q     <= (state_d == ST_HALT);
         fault_q      <= (state_d == ST_FAULT);
      end
   end

   assign fetch_req  = fetch_req_q;
   assign ir         = ir_q;
   assign op_start   = op_start_q;
   assign busy       = busy_q;
   assign halted     = halted_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Self-checking bench for instr_dispatch_ctrl: directed vector table,
// randomized transactions against a transaction-level model, and
// hand-written sequences for run drop, counter wrap, async reset and HALT.
module tb_instr_dispatch_ctrl;

   localparam logic [15:0] OP_EN_TB   = 16'h003F;
   localparam int          TIMEOUT_TB = 32;
   localparam int          LAST       = TIMEOUT_TB - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        clear_fault = 1'b0;
   logic [15:0] instr_in = 16'h0000;
   logic        instr_valid = 1'b0;
   logic [15:0] op_done = 16'h0000;
   logic        fetch_req;
   logic [15:0] ir;
   logic [15:0] op_start;
   logic        busy;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_code;
   logic [15:0] retire_cnt;

   int total = 0;
   int bad   = 0;
   logic [15:0] model_cnt = 16'h0000;

   instr_dispatch_ctrl #(.OP_EN(OP_EN_TB), .TIMEOUT(TIMEOUT_TB)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .clear_fault (clear_fault),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .op_done     (op_done),
      .fetch_req   (fetch_req),
      .ir          (ir),
      .op_start    (op_start),
      .busy        (busy),
      .halted      (halted),
      .fault       (fault),
      .fault_code  (fault_code),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      int          d;      // EXEC cycle index carrying the matching done
      logic [15:0] spur;   // stray done bits, 0 = none
      int          s;      // EXEC cycle index carrying the stray bits
      logic [1:0]  fc;     // expected fault code, 0 = retires
      int          k;      // EXEC cycle index at which the outcome is decided
      logic [15:0] cnt;    // expected retire count afterwards
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_seq();
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      check("clear_fault", fault, 0);
      check("clear_code", fault_code, 0);
      check("clear_busy", busy, 0);
   endtask

   // One instruction from fetch to outcome; starts and ends at a negedge
   task automatic run_instr(input vec_t v, input bit drop_run);
      int n = 0;
      logic [3:0] op = v.instr[15:12];
      logic [15:0] sel = 16'h0001 << op;
      while (!fetch_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("fetch_wait", fetch_req, 1);
      instr_in    = v.instr;
      instr_valid = 1'b1;
      @(negedge clk);
      check("decode_ir", ir, v.instr);
      check("decode_fetch_req", fetch_req, 0);
      check("decode_op_start", op_start, 0);
      instr_valid = 1'b0;
      instr_in    = 16'(($urandom));
      @(negedge clk);
      if (op == 4'hF) begin
         check("halt_flag", halted, 1);
         check("halt_busy", busy, 0);
         $display("instr %h -> halt", v.instr);
         return;
      end
      if (v.fc == 2'b01) begin
         check("illegal_fault", fault, 1);
         check("illegal_code", fault_code, 1);
         check("illegal_ir", ir, v.instr);
         check("illegal_op_start", op_start, 0);
         $display("instr %h -> fault %0d", v.instr, fault_code);
         clear_seq();
         return;
      end
      check("exec_op_start", op_start, sel);
      if (drop_run) run = 1'b0;
      for (int k = 0; k <= v.k; k++) begin
         op_done = ((k == v.d) ? sel : 16'h0000) | ((k == v.s) ? v.spur : 16'h0000);
         @(negedge clk);
         op_done = 16'h0000;
         if (k < v.k) begin
            check("exec_wait_fault", fault, 0);
            check("exec_wait_op_start", op_start, 0);
         end
      end
      if (v.fc == 2'b00) begin
         check("retire_fault", fault, 0);
         check("retire_busy", busy, 1);
         @(negedge clk);
         check("after_retire_fetch_req", fetch_req, drop_run ? 0 : 1);
         check("retire_cnt", retire_cnt, v.cnt);
         $display("instr %h -> retired cnt=%0d", v.instr, retire_cnt);
      end else begin
         check("fault_flag", fault, 1);
         check("fault_code", fault_code, v.fc);
         check("fault_ir", ir, v.instr);
         check("fault_busy", busy, 0);
         $display("instr %h -> fault %0d", v.instr, fault_code);
         clear_seq();
      end
   endtask

   // Transaction-level outcome from the opcode enable mask and event times
   function automatic vec_t predict(input logic [15:0] instr, input int d,
                                    input logic [15:0] spur, input int s);
      vec_t v;
      logic [3:0] op = instr[15:12];
      v.instr = instr; v.d = d; v.spur = spur; v.s = (spur != 0) ? s : -1;
      if (!OP_EN_TB[op]) begin
         v.fc = 2'b01; v.k = 0;
      end else if (spur != 0 && s <= d && s <= LAST) begin
         v.fc = 2'b11; v.k = s;
      end else if (d <= LAST) begin
         v.fc = 2'b00; v.k = d; model_cnt = model_cnt + 16'd1;
      end else begin
         v.fc = 2'b10; v.k = LAST;
      end
      v.cnt = model_cnt;
      return v;
   endfunction

   vec_t tbl[10];

   initial begin
      tbl[0] = '{16'h5043, 3,   16'h0000, -1, 2'b00, 3,    16'd1};
      tbl[1] = '{16'h7000, 0,   16'h0000, -1, 2'b01, 0,    16'd1};
      tbl[2] = '{16'h1234, 999, 16'h0000, -1, 2'b10, LAST, 16'd1};
      tbl[3] = '{16'h1FFF, LAST,16'h0000, -1, 2'b00, LAST, 16'd2};
      tbl[4] = '{16'h2041, 5,   16'h0008, 1,  2'b11, 1,    16'd2};
      tbl[5] = '{16'h3000, 2,   16'h0010, 2,  2'b11, 2,    16'd2};
      tbl[6] = '{16'h0FFF, 0,   16'h0000, -1, 2'b00, 0,    16'd3};
      tbl[7] = '{16'h5001, 1,   16'h0000, -1, 2'b00, 1,    16'd4};
      tbl[8] = '{16'hC000, 0,   16'h0000, -1, 2'b01, 0,    16'd4};
      tbl[9] = '{16'h4ABC, 30,  16'h0000, -1, 2'b00, 30,   16'd5};

      // Reset values, asserted asynchronously at time zero
      #1;
      check("rst_fetch_req", fetch_req, 0);
      check("rst_ir", ir, 0);
      check("rst_op_start", op_start, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fault, 0);
      check("rst_fault_code", fault_code, 0);
      check("rst_retire_cnt", retire_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_run", busy, 0);
      run = 1'b1;

      // Directed vector table
      for (int i = 0; i < 10; i++) run_instr(tbl[i], 1'b0);
      model_cnt = 16'd5;

      // Randomized transactions against the model
      for (int i = 0; i < 60; i++) begin
         logic [3:0] op = 4'($urandom_range(0, 14));
         int d = int'($urandom_range(0, 40));
         logic [15:0] spur = 16'h0000;
         int s = int'($urandom_range(0, 29));
         logic [15:0] w = 16'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            logic [3:0] b = 4'($urandom_range(0, 15));
            if (b == op) b = b + 4'd1;
            spur = 16'h0001 << b;
         end
         run_instr(predict({op, w[11:0]}, d, spur, s), 1'b0);
      end

      // Dropping run mid-instruction: it retires, then the sequencer idles
      begin
         vec_t v;
         v = predict(16'h5007, 4, 16'h0000, 0);
         run_instr(v, 1'b1);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rundrop_fetch_req", fetch_req, 0);
            check("rundrop_busy", busy, 0);
         end
      end

      // Counter wrap: start from an all-ones count instead of 65535 retirements
      force dut.retire_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.retire_cnt_q;
      model_cnt = 16'hFFFF;
      run = 1'b1;
      run_instr(predict(16'h5001, 0, 16'h0000, 0), 1'b0);
      check("wrap_zero", retire_cnt, 16'h0000);

      // Asynchronous reset between edges while in EXEC
      begin
         int n = 0;
         while (!fetch_req && n < 20) begin
            @(negedge clk);
            n++;
         end
         instr_in = 16'h1000; instr_valid = 1'b1;
         @(negedge clk);
         instr_valid = 1'b0;
         @(negedge clk);
         check("arst_op_start_pre", op_start, 16'h0002);
         @(negedge clk);
         #2 rst = 1'b1;
         #1;
         check("arst_fetch_req", fetch_req, 0);
         check("arst_ir", ir, 0);
         check("arst_op_start", op_start, 0);
         check("arst_busy", busy, 0);
         check("arst_halted", halted, 0);
         check("arst_fault", fault, 0);
         check("arst_fault_code", fault_code, 0);
         check("arst_retire_cnt", retire_cnt, 0);
         $display("async reset mid-exec -> outputs cleared");
         run = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         model_cnt = 16'h0000;
         op_done = 16'h0002;
         @(negedge clk);
         op_done = 16'h0000;
         check("idle_done_ignored", fault, 0);
         run = 1'b1;
      end

      // HALT: one retire, then halted holds against run and done activity
      run_instr(predict(16'h5001, 2, 16'h0000, 0), 1'b0);
      run_instr('{16'hF000, 0, 16'h0000, -1, 2'b00, 0, 16'd1}, 1'b0);
      for (int i = 0; i < 8; i++) begin
         run = i[0];
         op_done = 16'($urandom);
         @(negedge clk);
         check("halt_hold", halted, 1);
         check("halt_fetch_req", fetch_req, 0);
         check("halt_cnt", retire_cnt, 1);
      end
      op_done = 16'h0000;
      rst = 1'b1;
      #1;
      check("halt_exit_rst", halted, 0);
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time guard so the run always ends
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
